// File: rtl/m2_pkg.sv
// m2_pkg: shared types, defaults and the IDCT coefficient table for the milestone-2 datapath.
package m2_pkg;
    localparam int ADDR_W = 7;
    localparam logic [ADDR_W-1:0] T_OFFSET_DEF = 7'd0;
    localparam logic [ADDR_W-1:0] S_OFFSET_DEF = 7'd64;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

    // Row-major C[k][i], Q12 scaled DCT basis
    localparam logic signed [11:0] C_TAB [64] = '{
        12'sd1448,  12'sd1448,  12'sd1448,  12'sd1448,  12'sd1448,  12'sd1448,  12'sd1448,  12'sd1448,
        12'sd2009,  12'sd1703,  12'sd1138,  12'sd400,  -12'sd400,  -12'sd1138, -12'sd1703, -12'sd2009,
        12'sd1892,  12'sd784,  -12'sd784,  -12'sd1892, -12'sd1892, -12'sd784,   12'sd784,   12'sd1892,
        12'sd1703, -12'sd400,  -12'sd2009, -12'sd1138,  12'sd1138,  12'sd2009,  12'sd400,  -12'sd1703,
        12'sd1448, -12'sd1448, -12'sd1448,  12'sd1448,  12'sd1448, -12'sd1448, -12'sd1448,  12'sd1448,
        12'sd1138, -12'sd2009,  12'sd400,   12'sd1703, -12'sd1703, -12'sd400,   12'sd2009, -12'sd1138,
        12'sd784,  -12'sd1892,  12'sd1892, -12'sd784,  -12'sd784,   12'sd1892, -12'sd1892,  12'sd784,
        12'sd400,  -12'sd1138,  12'sd1703, -12'sd2009,  12'sd2009, -12'sd1703,  12'sd1138, -12'sd400
    };

    function automatic logic signed [11:0] c_coef(input logic [2:0] k, input logic [2:0] i);
        return C_TAB[{k, i}];
    endfunction
endpackage

// File: rtl/m2_idct_col_if.sv
// m2_idct_col_if: start/done handshake plus the T read port and S write port of the shared RAM.
interface m2_idct_col_if;
    import m2_pkg::*;
    logic                    Start;
    logic signed [31:0]      read_data_T;
    logic [ADDR_W-1:0]       address_T;
    logic [ADDR_W-1:0]       address_S;
    logic signed [31:0]      write_data_S;
    logic                    write_en_S;
    logic                    Done;
    modport master (input Start, read_data_T, output address_T, address_S, write_data_S, write_en_S, Done);
    modport slave  (output Start, read_data_T, input address_T, address_S, write_data_S, write_en_S, Done);
endinterface

// File: rtl/m2_mac_unit.sv
// m2_mac_unit: 32x12 signed multiply into a 47-bit accumulator, result taken as acc >>> 16.
module m2_mac_unit (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic signed [31:0] data_i,
    input  logic signed [11:0] coef_i,
    output logic signed [31:0] res_o
);
    logic signed [43:0] prod;
    logic signed [46:0] acc_q, acc_d;

    always_comb begin
        prod  = 44'(data_i) * 44'(coef_i);
        acc_d = clr_i ? 47'(prod) : acc_q + 47'(prod);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) acc_q <= '0;
        else if (en_i) acc_q <= acc_d;

    assign res_o = 32'(acc_q >>> 16);
endmodule

// File: rtl/m2_idct_col.sv
// m2_idct_col: column pass S = C^T * T, one MAC per clock, reading T from and writing S to the shared RAM.
module m2_idct_col
    import m2_pkg::*;
#(
    parameter logic [ADDR_W-1:0] T_OFFSET = T_OFFSET_DEF,
    parameter logic [ADDR_W-1:0] S_OFFSET = S_OFFSET_DEF
) (
    input logic CLOCK_50,
    input logic Reset,
    m2_idct_col_if.master bus
);
    state_t state_q, state_d;
    logic [8:0] n_q;
    logic [ADDR_W-1:0] address_T_q, address_S_q;
    logic signed [31:0] write_data_q, res;
    logic write_en_q, wr_q, v1_q, v2_q, l1_q, l2_q, issue, done;
    logic [2:0] k1_q, k2_q, i1_q, i2_q;
    logic [5:0] e_q;

    assign done = state_q == FINISH;

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: if (bus.Start && !done) begin
                state_d = RUN;
                issue   = 1'b1;
            end
            RUN: begin
                issue   = 1'b1;
                state_d = &n_q ? DRAIN : RUN;
            end
            DRAIN:  state_d = write_en_q ? FINISH : DRAIN;
            FINISH: state_d = IDLE;
        endcase
    end

    // n = 64i + 8j + k; k, i and the last-term flag ride two stages alongside the RAM latency
    always_ff @(posedge CLOCK_50 or posedge Reset)
        if (Reset) begin
            state_q <= IDLE;
            n_q <= '0;
            address_T_q <= '0;
            address_S_q <= '0;
            write_data_q <= '0;
            write_en_q <= 1'b0;
            wr_q <= 1'b0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            l1_q <= 1'b0;
            l2_q <= 1'b0;
            k1_q <= '0;
            k2_q <= '0;
            i1_q <= '0;
            i2_q <= '0;
            e_q <= '0;
        end else begin
            state_q <= state_d;
            v1_q <= issue;
            v2_q <= v1_q;
            l2_q <= l1_q;
            k2_q <= k1_q;
            i2_q <= i1_q;
            if (issue) begin
                n_q <= n_q + 9'd1;
                address_T_q <= T_OFFSET + {1'b0, n_q[2:0], n_q[5:3]};
                k1_q <= n_q[2:0];
                i1_q <= n_q[8:6];
                l1_q <= &n_q[2:0];
            end
            wr_q <= v2_q && l2_q;
            write_en_q <= wr_q;
            if (wr_q) begin
                address_S_q <= S_OFFSET + {1'b0, e_q};
                write_data_q <= res;
                e_q <= e_q + 6'd1;
            end
        end

    m2_mac_unit u_mac (
        .clk    (CLOCK_50),
        .rst    (Reset),
        .en_i   (v2_q),
        .clr_i  (k2_q == 3'd0),
        .data_i (bus.read_data_T),
        .coef_i (c_coef(k2_q, i2_q)),
        .res_o  (res)
    );

    assign bus.address_T    = address_T_q;
    assign bus.address_S    = address_S_q;
    assign bus.write_data_S = write_data_q;
    assign bus.write_en_S   = write_en_q;
    assign bus.Done         = done;
endmodule

// File: tb/tb_m2_idct_col.sv
// tb_m2_idct_col: directed passes against a 2-cycle-latency RAM model with hand-computed S values.
module tb_m2_idct_col;
    logic clk, rst, prev_we;
    int cyc = 0;
    int s0, n_chk, n_pass, b2b;
    logic signed [31:0] tmem [128];
    logic signed [31:0] rd_q;
    int wr_rel[$], wr_adr[$], wr_dat[$], done_rel[$];
    int exp_s[64];
    int r1[8] = '{2009, 1703, 1138, 400, -400, -1138, -1703, -2009};
    int r3[8] = '{1703, -400, -2009, -1138, 1138, 2009, 400, -1703};
    int r7[8] = '{400, -1138, 1703, -2009, 2009, -1703, 1138, -400};
    int mx[8] = '{2394, 1839, 1056, 501, 501, 1056, 1839, 2394};

    m2_idct_col_if bus();
    m2_idct_col dut (.CLOCK_50(clk), .Reset(rst), .bus(bus.master));

    assign bus.read_data_T = rd_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rd_q <= tmem[bus.address_T];
    end

    initial begin
        prev_we = 1'b0;
        b2b = 0;
    end

    always @(negedge clk)
        if (!rst) begin
            if (bus.write_en_S) begin
                wr_rel.push_back(cyc - s0);
                wr_adr.push_back(int'(bus.address_S));
                wr_dat.push_back(int'(bus.write_data_S));
                if (prev_we) b2b = b2b + 1;
            end
            if (bus.Done) done_rel.push_back(cyc - s0);
            prev_we = bus.write_en_S;
        end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic clear_logs();
        wr_rel.delete();
        wr_adr.delete();
        wr_dat.delete();
        done_rel.delete();
    endtask

    task automatic zero_t();
        for (int a = 0; a < 128; a++) tmem[a] = '0;
        for (int e = 0; e < 64; e++) exp_s[e] = 0;
    endtask

    task automatic check_outs_zero(input string tag);
        chk({tag, ":address_T"}, int'(bus.address_T), 0);
        chk({tag, ":address_S"}, int'(bus.address_S), 0);
        chk({tag, ":write_data_S"}, int'(bus.write_data_S), 0);
        chk({tag, ":write_en_S"}, int'(bus.write_en_S), 0);
        chk({tag, ":Done"}, int'(bus.Done), 0);
    endtask

    task automatic verify(input string tag, input int base, input int off);
        for (int e = 0; e < 64; e++)
            if (off + e < wr_rel.size()) begin
                chk($sformatf("%s:edge[%0d]", tag, e), wr_rel[off+e], base + 8*e + 10);
                chk($sformatf("%s:addr[%0d]", tag, e), wr_adr[off+e], 64 + e);
                chk($sformatf("%s:data[%0d]", tag, e), wr_dat[off+e], exp_s[e]);
            end
    endtask

    task automatic do_pass(input string tag);
        clear_logs();
        @(negedge clk);
        s0 = cyc + 1;
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        for (int c = 0; c < 700 && done_rel.size() == 0; c++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk({tag, ":writes"}, wr_rel.size(), 64);
        verify(tag, 0, 0);
        chk({tag, ":done_n"}, done_rel.size(), 1);
        if (done_rel.size() > 0) chk({tag, ":done_edge"}, done_rel[0], 515);
        chk({tag, ":b2b"}, b2b, 0);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        s0 = 0;
        rst = 1'b1;
        bus.Start = 1'b0;
        zero_t();
        repeat (3) @(negedge clk);
        check_outs_zero("reset");
        rst = 1'b0;

        do_pass("zero");

        tmem[0] = 32'sd65536;
        for (int i = 0; i < 8; i++) exp_s[8*i] = 1448;
        do_pass("dc_pos");

        tmem[0] = -32'sd65536;
        for (int i = 0; i < 8; i++) exp_s[8*i] = -1448;
        do_pass("dc_neg");

        tmem[0] = -32'sd1;
        for (int i = 0; i < 8; i++) exp_s[8*i] = -1;
        do_pass("dc_m1");

        zero_t();
        tmem[8*1 + 0] = 32'sd65536;
        tmem[8*3 + 5] = 32'sd65536;
        tmem[8*7 + 3] = -32'sd131072;
        tmem[8*0 + 1] = 32'sd65536;
        tmem[8*2 + 1] = 32'sd32768;
        tmem[8*6 + 1] = 32'sd1;
        for (int i = 0; i < 8; i++) begin
            exp_s[8*i + 0] = r1[i];
            exp_s[8*i + 5] = r3[i];
            exp_s[8*i + 3] = -2 * r7[i];
            exp_s[8*i + 1] = mx[i];
        end
        do_pass("mixed");

        clear_logs();
        @(negedge clk);
        s0 = cyc + 1;
        bus.Start = 1'b1;
        for (int c = 0; c < 1300 && done_rel.size() < 2; c++) @(negedge clk);
        bus.Start = 1'b0;
        repeat (4) @(negedge clk);
        chk("held:writes", wr_rel.size(), 128);
        verify("held1", 0, 0);
        verify("held2", 517, 64);
        chk("held:done_n", done_rel.size(), 2);
        if (done_rel.size() > 1) begin
            chk("held:done0", done_rel[0], 515);
            chk("held:done1", done_rel[1], 1032);
        end
        chk("held:b2b", b2b, 0);

        clear_logs();
        @(negedge clk);
        s0 = cyc + 1;
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (198) @(negedge clk);
        rst = 1'b1;
        #1;
        check_outs_zero("abort");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort:writes", wr_rel.size(), 24);
        verify("abort", 0, 0);
        do_pass("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
